// File: rtl/sdram_port_scheduler.sv
// sdram_port_scheduler
//   Shares one 16-bit SDRAM controller command port between three requesters:
//   video (BURST_LEN-word burst reads), CPU and DMA (single-word read/write).
//   Video has fixed priority but is capped at MAX_VID_RUN consecutive grants
//   while CPU/DMA is waiting. CPU and DMA alternate round-robin. Only one
//   transaction is in flight at a time.
// Ports
//   clk_i, rst_n_i                 clock, synchronous active-low reset
//   vid_*                          video request / grant / per-word ack
//   cpu_*, dma_*                   single-word requesters (rd/wr level requests)
//   rdata                          shared read data (passthrough of sdram_rdata)
//   sdram_rd/wr/addr/wdata/wmask   latched command to the controller
//   sdram_burst                    1 while a video burst is in progress
//   sdram_rdy/ack/rdata            controller handshake and read data
module sdram_port_scheduler #(
   parameter int ADDR_W      = 24,
   parameter int BURST_LEN   = 4,
   parameter int MAX_VID_RUN = 4
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              vid_rd,
   input  logic [ADDR_W-1:0] vid_addr_x16,
   output logic              vid_gnt,
   output logic              vid_ack,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr_x16,
   input  logic [15:0]       cpu_wdata,
   input  logic [1:0]        cpu_wmask,
   output logic              cpu_gnt,
   output logic              cpu_ack,
   input  logic              dma_rd,
   input  logic              dma_wr,
   input  logic [ADDR_W-1:0] dma_addr_x16,
   input  logic [15:0]       dma_wdata,
   input  logic [1:0]        dma_wmask,
   output logic              dma_gnt,
   output logic              dma_ack,
   output logic [15:0]       rdata,
   output logic              sdram_rd,
   output logic              sdram_wr,
   output logic [ADDR_W-1:0] sdram_addr_x16,
   output logic [15:0]       sdram_wdata,
   output logic [1:0]        sdram_wmask,
   output logic              sdram_burst,
   input  logic              sdram_rdy,
   input  logic              sdram_ack,
   input  logic [15:0]       sdram_rdata
);

   localparam int RUN_W = $clog2(MAX_VID_RUN + 1);
   localparam int CNT_W = $clog2(BURST_LEN);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;
   typedef enum logic [1:0] {OWN_VID, OWN_CPU, OWN_DMA} owner_t;

   state_t             state_q;
   owner_t             owner_q;
   logic               is_wr_q;
   logic               rr_dma_q;      // 0: CPU has round-robin priority
   logic [RUN_W-1:0]   vid_run_q;
   logic [CNT_W-1:0]   ack_cnt_q;
   logic               sdram_rd_q, sdram_wr_q, sdram_burst_q;
   logic [ADDR_W-1:0]  sdram_addr_q;
   logic [15:0]        sdram_wdata_q;
   logic [1:0]         sdram_wmask_q;
   logic               vid_gnt_q, cpu_gnt_q, dma_gnt_q;
   logic               cpu_wack_q, dma_wack_q;

   logic               cpu_req, dma_req, cd_pend;
   logic               vid_win_d, cpu_win_d, dma_win_d, start_d;
   logic               rd_ack_d;
   logic [CNT_W-1:0]   last_cnt_d;

   assign cpu_req = cpu_rd | cpu_wr;
   assign dma_req = dma_rd | dma_wr;
   assign cd_pend = cpu_req | dma_req;

   // The cap only blocks video when someone else is actually waiting.
   assign vid_win_d = vid_rd && ((vid_run_q < RUN_W'(MAX_VID_RUN)) || !cd_pend);
   assign cpu_win_d = !vid_win_d && cpu_req && (!dma_req || !rr_dma_q);
   assign dma_win_d = !vid_win_d && !cpu_win_d && dma_req;
   assign start_d   = sdram_rdy && (vid_rd || cd_pend);

   assign last_cnt_d = (owner_q == OWN_VID) ? CNT_W'(BURST_LEN - 1) : '0;
   assign rd_ack_d   = (state_q == WAIT_RD) && sdram_ack;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q       <= IDLE;
         owner_q       <= OWN_VID;
         is_wr_q       <= 1'b0;
         rr_dma_q      <= 1'b0;
         vid_run_q     <= '0;
         ack_cnt_q     <= '0;
         sdram_rd_q    <= 1'b0;
         sdram_wr_q    <= 1'b0;
         sdram_burst_q <= 1'b0;
         sdram_addr_q  <= '0;
         sdram_wdata_q <= '0;
         sdram_wmask_q <= '0;
         vid_gnt_q     <= 1'b0;
         cpu_gnt_q     <= 1'b0;
         dma_gnt_q     <= 1'b0;
         cpu_wack_q    <= 1'b0;
         dma_wack_q    <= 1'b0;
      end else begin
         // Strobes, grants and write acks are one-cycle pulses in ISSUE.
         sdram_rd_q <= 1'b0;
         sdram_wr_q <= 1'b0;
         vid_gnt_q  <= 1'b0;
         cpu_gnt_q  <= 1'b0;
         dma_gnt_q  <= 1'b0;
         cpu_wack_q <= 1'b0;
         dma_wack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // Run length only counts video grants made while CPU/DMA waits.
               if (!cd_pend) vid_run_q <= '0;
               if (start_d) begin
                  state_q   <= ISSUE;
                  ack_cnt_q <= '0;
                  if (vid_win_d) begin
                     owner_q       <= OWN_VID;
                     is_wr_q       <= 1'b0;
                     sdram_addr_q  <= vid_addr_x16;
                     sdram_wdata_q <= '0;
                     sdram_wmask_q <= '0;
                     sdram_burst_q <= 1'b1;
                     sdram_rd_q    <= 1'b1;
                     vid_gnt_q     <= 1'b1;
                     if (cd_pend && vid_run_q != RUN_W'(MAX_VID_RUN))
                        vid_run_q <= vid_run_q + RUN_W'(1);
                  end else if (cpu_win_d) begin
                     owner_q       <= OWN_CPU;
                     is_wr_q       <= cpu_wr;      // rd+wr together acts as a write
                     sdram_addr_q  <= cpu_addr_x16;
                     sdram_wdata_q <= cpu_wdata;
                     sdram_wmask_q <= cpu_wmask;
                     sdram_burst_q <= 1'b0;
                     sdram_rd_q    <= !cpu_wr;
                     sdram_wr_q    <= cpu_wr;
                     cpu_wack_q    <= cpu_wr;
                     cpu_gnt_q     <= 1'b1;
                     rr_dma_q      <= 1'b1;
                     vid_run_q     <= '0;
                  end else if (dma_win_d) begin
                     owner_q       <= OWN_DMA;
                     is_wr_q       <= dma_wr;
                     sdram_addr_q  <= dma_addr_x16;
                     sdram_wdata_q <= dma_wdata;
                     sdram_wmask_q <= dma_wmask;
                     sdram_burst_q <= 1'b0;
                     sdram_rd_q    <= !dma_wr;
                     sdram_wr_q    <= dma_wr;
                     dma_wack_q    <= dma_wr;
                     dma_gnt_q     <= 1'b1;
                     rr_dma_q      <= 1'b0;
                     vid_run_q     <= '0;
                  end
               end
            end
            ISSUE: state_q <= is_wr_q ? IDLE : WAIT_RD;
            WAIT_RD: begin
               if (sdram_ack) begin
                  if (ack_cnt_q == last_cnt_d) begin
                     state_q       <= IDLE;
                     sdram_burst_q <= 1'b0;
                  end else begin
                     ack_cnt_q <= ack_cnt_q + CNT_W'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sdram_rd       = sdram_rd_q;
   assign sdram_wr       = sdram_wr_q;
   assign sdram_burst    = sdram_burst_q;
   assign sdram_addr_x16 = sdram_addr_q;
   assign sdram_wdata    = sdram_wdata_q;
   assign sdram_wmask    = sdram_wmask_q;
   assign vid_gnt        = vid_gnt_q;
   assign cpu_gnt        = cpu_gnt_q;
   assign dma_gnt        = dma_gnt_q;
   assign rdata          = sdram_rdata;
   // Read acks go straight through to whoever owns the read in flight.
   assign vid_ack = rd_ack_d && (owner_q == OWN_VID);
   assign cpu_ack = (rd_ack_d && (owner_q == OWN_CPU)) || cpu_wack_q;
   assign dma_ack = (rd_ack_d && (owner_q == OWN_DMA)) || dma_wack_q;

endmodule

// File: tb/tb_sdram_port_scheduler.sv
module tb_sdram_port_scheduler;
   localparam int AW = 24;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          vid_rd = 0, cpu_rd = 0, cpu_wr = 0, dma_rd = 0, dma_wr = 0;
   logic [AW-1:0] vid_addr = 24'h100000, cpu_addr = 24'h000123, dma_addr = 24'h0ABCDE;
   logic [15:0]   cpu_wdata = 0, dma_wdata = 0;
   logic [1:0]    cpu_wmask = 0, dma_wmask = 0;
   logic          sdram_rdy = 0, sdram_ack = 0;
   logic [15:0]   sdram_rdata = 0;
   logic          vid_gnt, vid_ack, cpu_gnt, cpu_ack, dma_gnt, dma_ack;
   logic [15:0]   rdata, sdram_wdata;
   logic          sdram_rd, sdram_wr, sdram_burst;
   logic [AW-1:0] sdram_addr;
   logic [1:0]    sdram_wmask;

   sdram_port_scheduler #(.ADDR_W(AW), .BURST_LEN(4), .MAX_VID_RUN(4)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .vid_rd(vid_rd), .vid_addr_x16(vid_addr), .vid_gnt(vid_gnt), .vid_ack(vid_ack),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr_x16(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_wmask(cpu_wmask), .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack),
      .dma_rd(dma_rd), .dma_wr(dma_wr), .dma_addr_x16(dma_addr), .dma_wdata(dma_wdata),
      .dma_wmask(dma_wmask), .dma_gnt(dma_gnt), .dma_ack(dma_ack),
      .rdata(rdata), .sdram_rd(sdram_rd), .sdram_wr(sdram_wr),
      .sdram_addr_x16(sdram_addr), .sdram_wdata(sdram_wdata), .sdram_wmask(sdram_wmask),
      .sdram_burst(sdram_burst), .sdram_rdy(sdram_rdy), .sdram_ack(sdram_ack),
      .sdram_rdata(sdram_rdata)
   );

   // {sdram_rd, sdram_wr, sdram_burst, vid_gnt, cpu_gnt, dma_gnt, vid_ack, cpu_ack, dma_ack}
   wire [8:0] outs = {sdram_rd, sdram_wr, sdram_burst, vid_gnt, cpu_gnt, dma_gnt,
                      vid_ack, cpu_ack, dma_ack};

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_reset();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   // in bits: {vid_rd, cpu_rd, cpu_wr, dma_rd, dma_wr, sdram_rdy, sdram_ack}
   typedef struct {
      logic [6:0]  in;
      logic [15:0] rd;
      logic [8:0]  exp;
   } vec_t;

   task automatic drive(input logic [6:0] in, input logic [15:0] rd);
      {vid_rd, cpu_rd, cpu_wr, dma_rd, dma_wr, sdram_rdy, sdram_ack} = in;
      sdram_rdata = rd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv[$];
      vec_t v;

      // CPU read of 0x000123, controller acks 3 cycles after the strobe,
      // then a stray ack in IDLE, then a 4-word video burst.
      tv.push_back('{7'b0100010, 16'h0000, 9'b000000000});
      tv.push_back('{7'b0100010, 16'h0000, 9'b100010000});
      tv.push_back('{7'b0000010, 16'h0000, 9'b000000000});
      tv.push_back('{7'b0000010, 16'h0000, 9'b000000000});
      tv.push_back('{7'b0000011, 16'hBEEF, 9'b000000010});
      tv.push_back('{7'b0000010, 16'h0000, 9'b000000000});
      tv.push_back('{7'b0000011, 16'h5555, 9'b000000000});
      tv.push_back('{7'b1000010, 16'h0000, 9'b000000000});
      tv.push_back('{7'b1000010, 16'h0000, 9'b101100000});
      tv.push_back('{7'b0000010, 16'h0000, 9'b001000000});
      tv.push_back('{7'b0000011, 16'h0001, 9'b001000100});
      tv.push_back('{7'b0000011, 16'h0002, 9'b001000100});
      tv.push_back('{7'b0000010, 16'h0000, 9'b001000000});
      tv.push_back('{7'b0000011, 16'h0003, 9'b001000100});
      tv.push_back('{7'b0000011, 16'h0004, 9'b001000100});
      tv.push_back('{7'b0000010, 16'h0000, 9'b000000000});

      // Reset state
      rst_n = 1'b0;
      step();
      step();
      smp();
      chk("reset_outputs", {outs, sdram_addr, sdram_wdata, sdram_wmask}, 64'h0);
      step();
      rst_n = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < tv.size(); i++) begin
         v = tv[i];
         step();
         drive(v.in, v.rd);
         smp();
         chk($sformatf("vec%0d", i), {outs, rdata}, {v.exp, v.rd});
         if (v.exp[8])
            chk($sformatf("vec%0d_addr", i), sdram_addr, v.exp[5] ? vid_addr : cpu_addr);
      end

      // CPU/DMA writes held together: C, D, C, D with per-grant data/mask
      do_reset();
      cpu_wdata = 16'hC000; cpu_wmask = 2'b01;
      dma_wdata = 16'hD000; dma_wmask = 2'b10;
      cpu_wr = 1; dma_wr = 1; sdram_rdy = 1; sdram_ack = 0;
      begin
         int g = 0;
         for (int c = 0; c < 30 && g < 4; c++) begin
            step();
            smp();
            if (cpu_gnt || dma_gnt) begin
               logic wd;
               wd = g[0];
               chk($sformatf("rr_grant%0d", g),
                   {cpu_gnt, dma_gnt, sdram_wr, sdram_rd, cpu_ack, dma_ack, sdram_wdata, sdram_wmask},
                   {~wd, wd, 1'b1, 1'b0, ~wd, wd,
                    wd ? 16'(16'hD000 + g/2) : 16'(16'hC000 + g/2),
                    wd ? 2'b10 : 2'b01});
               if (cpu_gnt) cpu_wdata = cpu_wdata + 16'd1;
               else         dma_wdata = dma_wdata + 16'd1;
               g++;
            end
         end
         chk("rr_grant_count", g, 4);
      end
      step();
      cpu_wr = 0; dma_wr = 0;

      // Video + CPU held: V,V,V,V,C,V,V,V,V,C with a small controller model
      do_reset();
      begin
         string exps = "VVVVCVVVVC";
         byte   got[10];
         int    n = 0, pend = 0, nva = 0;
         cpu_wr = 1; vid_rd = 1; sdram_rdy = 1;
         for (int c = 0; c < 300 && n < 10; c++) begin
            step();
            sdram_ack = (pend > 0);
            sdram_rdata = 16'(c);
            smp();
            if (sdram_ack) pend--;
            if (sdram_rd) pend += sdram_burst ? 4 : 1;
            if (vid_ack) nva++;
            if (vid_gnt || cpu_gnt || dma_gnt) begin
               got[n] = vid_gnt ? "V" : (cpu_gnt ? "C" : "D");
               n++;
            end
         end
         chk("cap_grant_count", n, 10);
         for (int i = 0; i < 10; i++)
            chk($sformatf("cap_grant%0d", i), (i < n) ? got[i] : 8'h3F, exps[i]);
         chk("cap_vid_acks", nva, 32);
      end
      step();
      cpu_wr = 0; vid_rd = 0; sdram_ack = 0;

      // Reset in WAIT_RD after 2 of 4 video acks; later acks are dropped
      do_reset();
      step(); vid_rd = 1; sdram_rdy = 1;
      step(); smp(); chk("rst_vid_gnt", {vid_gnt, sdram_rd, sdram_burst}, 3'b111);
      step(); vid_rd = 0;
      step(); sdram_ack = 1; sdram_rdata = 16'h0011; smp(); chk("rst_vack1", vid_ack, 1'b1);
      step(); sdram_rdata = 16'h0022; smp(); chk("rst_vack2", vid_ack, 1'b1);
      step(); sdram_ack = 0; rst_n = 0;
      step(); rst_n = 1; sdram_ack = 1; sdram_rdata = 16'h0033; smp();
      chk("rst_late_ack1", {outs, sdram_addr, sdram_wdata, sdram_wmask}, 64'h0);
      step(); sdram_rdata = 16'h0044; smp();
      chk("rst_late_ack2", {outs, sdram_addr, sdram_wdata, sdram_wmask}, 64'h0);
      step(); sdram_ack = 0; cpu_rd = 1; sdram_rdata = 0;
      smp(); chk("rst_after_idle", outs, 9'b0);
      step(); smp(); chk("rst_after_gnt", {outs, sdram_addr}, {9'b100010000, cpu_addr});
      step(); cpu_rd = 0;
      step(); sdram_ack = 1; sdram_rdata = 16'h1234; smp();
      chk("rst_after_ack", {outs, rdata}, {9'b000000010, 16'h1234});
      step(); sdram_ack = 0; sdram_rdata = 0;

      // sdram_rdy low for 10 cycles with a CPU write pending
      step(); sdram_rdy = 0; cpu_wr = 1; cpu_wdata = 16'hA5A5; cpu_wmask = 2'b11;
      begin
         int strobes = 0;
         for (int c = 0; c < 10; c++) begin
            step();
            smp();
            strobes += int'(sdram_wr | sdram_rd | cpu_gnt);
         end
         chk("rdy_low_no_strobe", strobes, 0);
      end
      step(); sdram_rdy = 1; smp();
      chk("rdy_rise_same_cycle", {sdram_wr, cpu_gnt}, 2'b00);
      step(); smp();
      chk("rdy_rise_strobe", {sdram_wr, cpu_gnt, cpu_ack, sdram_wdata, sdram_wmask},
          {3'b111, 16'hA5A5, 2'b11});
      step(); cpu_wr = 0;
      step(); smp(); chk("rdy_done_idle", outs, 9'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sdram_port_scheduler.md
Name: sdram_port_scheduler

Overview:
- Shares the single 16-bit SDRAM controller port between three requesters: video fetch (burst reads), CPU (single-word read/write) and a DMA/blitter port (single-word read/write).
- Sits between the requester blocks and the SDRAM controller, and replaces the two-port arbitration path.
- Video has fixed priority, with a run-length cap so that CPU and DMA are never starved. CPU and DMA share the remaining slots round-robin.
- Exactly one transaction is outstanding at a time.

Parameters:
ADDR_W, 24, word (x16) address width
BURST_LEN, 4, read words returned per video burst (2..8)
MAX_VID_RUN, 4, max consecutive video grants while CPU/DMA is pending (>=1)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  synchronous active-low reset
vid_rd  in  1  video read request, level, held until vid_gnt
vid_addr_x16  in  ADDR_W  video burst start address
vid_gnt  out  1  1-cycle pulse: video request accepted
vid_ack  out  1  pulse per returned video word
cpu_rd / cpu_wr  in  1  CPU read/write request, level, mutually exclusive
cpu_addr_x16  in  ADDR_W  CPU address
cpu_wdata  in  16  CPU write data
cpu_wmask  in  2  CPU byte enables
cpu_gnt  out  1  CPU request accepted
cpu_ack  out  1  CPU read data valid / write done
dma_rd / dma_wr, dma_addr_x16, dma_wdata, dma_wmask, dma_gnt, dma_ack  same as cpu_*
rdata  out  16  shared read data (sdram_rdata passthrough)
sdram_rd / sdram_wr  out  1  1-cycle command strobes to controller
sdram_addr_x16  out  ADDR_W  latched command address
sdram_wdata  out  16  latched write data
sdram_wmask  out  2  latched byte enables
sdram_burst  out  1  1 = burst read of BURST_LEN words
sdram_rdy  in  1  controller can accept a command
sdram_ack  in  1  controller read-data-valid pulse
sdram_rdata  in  16  controller read data

Behaviour:
- Reset (rst_n_i=0 at a clock edge):
  - State goes to IDLE.
  - All strobes, gnt and ack outputs are 0; sdram_addr_x16, sdram_wdata, sdram_wmask and sdram_burst are 0.
  - Round-robin pointer selects CPU first; video run counter is 0.
  - Reset mid-transaction abandons it. Any later sdram_ack arriving in IDLE is dropped and produces no *_ack.
- States:
  - IDLE: if sdram_rdy=1 and any request is pending, arbitrate, latch the winner's address/data/mask/burst and owner ID, then go to ISSUE.
  - ISSUE (exactly 1 cycle): assert sdram_rd or sdram_wr plus the winner's *_gnt. Reads go to WAIT_RD; writes return to IDLE.
  - WAIT_RD: count sdram_ack pulses. After the last one (1 for CPU/DMA, BURST_LEN for video), return to IDLE.
- Arbitration, evaluated in IDLE only:
  - If vid_rd=1 and (vid_run < MAX_VID_RUN or no CPU/DMA request), grant video and increment vid_run (saturating).
  - Otherwise grant CPU or DMA by round-robin. The pointer toggles to the other port after each CPU/DMA grant. If only one of them is pending, it wins regardless of the pointer.
  - Any CPU/DMA grant clears vid_run to 0. vid_run also clears when no CPU/DMA request is pending in IDLE.
  - If the video cap blocks video and neither CPU nor DMA is pending, video wins. The cap never idles the bus.
- Latency and timing:
  - Request sampled in IDLE at cycle N → strobe and gnt at N+1.
  - Minimum back-to-back write spacing is 2 cycles.
  - Write *_ack pulses in the ISSUE cycle, together with gnt.
  - Read *_ack is combinational from sdram_ack, routed only to the latched owner, with 0-cycle delay. rdata = sdram_rdata at all times.
  - sdram_burst=1 only while the video transaction is in progress; it is 0 for CPU/DMA.
- Requester rules:
  - A requester deasserts its request the cycle after it sees gnt.
  - A request is never dropped before gnt; the scheduler never cancels a pending request.
  - cpu_rd and cpu_wr both high: treat as a write (verification asserts this as an illegal stimulus).
- Simultaneous and corner cases:
  - sdram_rdy=0 in IDLE: wait and hold all requests.
  - sdram_ack outside WAIT_RD: ignored.
  - Extra acks beyond the expected count cannot occur; the bench flags them as an error.

Test Plan:
- CPU read only, addr 0x000123, controller ack 3 cycles after strobe → sdram_rd at N+1, cpu_gnt at N+1, one cpu_ack with rdata=0xBEEF; vid_ack and dma_ack stay 0.
- Video burst, BURST_LEN=4, vid_addr 0x100000 → sdram_burst=1, 4 vid_ack pulses carrying 0x0001..0x0004, then back to IDLE.
- CPU and DMA writes requested together and held continuously → grants alternate CPU, DMA, CPU, DMA, with CPU first after reset; wmask and wdata are latched per grant.
- Video held continuously plus CPU held, MAX_VID_RUN=4 → grant sequence V,V,V,V,C,V,V,V,V,C.
- Reset asserted in WAIT_RD after 2 of 4 video acks, then 2 more sdram_ack arrive → no vid_ack pulses, all outputs 0, next request is served normally.
- sdram_rdy held low for 10 cycles with a CPU write pending → no strobe; strobe appears 1 cycle after sdram_rdy rises.
